// File: rtl/efuse_macro_responder.sv
// rtl/efuse_macro_responder.sv - eFuse macro responder model (optional lock bit via EFUSE_LOCK_EN)
module efuse_macro_responder #(
   parameter int NBITS         = 32,
   parameter int PGM_MIN_WIDTH = 4
) (
   input  logic             clk_1M,
   input  logic             rst,
   input  logic             CSB,
   input  logic             PGM,
   input  logic             SCLK,
   input  logic             DIN,
   output logic             DOUT,
   output logic [NBITS-1:0] fuse_data,
   output logic             prog_done,
   output logic             read_done,
   output logic             err_short,
   output logic             overrun
);

   localparam int IW = $clog2(NBITS + 1);

   typedef enum logic [1:0] {IDLE, PROG, READ} state_t;

   state_t           state;
   logic [IW-1:0]    idx;
   logic [7:0]       wcnt;
   logic [NBITS-1:0] fuse;

   logic s_csb, s_pgm, s_sclk, s_din;
   logic d_csb, d_pgm, d_sclk;

   logic          csb_fall, csb_rise, sclk_rise, sclk_fall;
   logic [IW-1:0] idx_inc;
   logic [NBITS-1:0] rd_next;
   logic          burn_ok;
   logic          unused_ok;

   // Two-stage pin sampling; CSB idles high so reset it that way to avoid a false edge.
   always_ff @(posedge clk_1M) begin
      if (rst) begin
         s_csb  <= 1'b1;
         d_csb  <= 1'b1;
         s_pgm  <= 1'b0;
         d_pgm  <= 1'b0;
         s_sclk <= 1'b0;
         d_sclk <= 1'b0;
         s_din  <= 1'b0;
      end else begin
         s_csb  <= CSB;
         d_csb  <= s_csb;
         s_pgm  <= PGM;
         d_pgm  <= s_pgm;
         s_sclk <= SCLK;
         d_sclk <= s_sclk;
         s_din  <= DIN;
      end
   end

   assign csb_fall  = d_csb & ~s_csb;
   assign csb_rise  = ~d_csb & s_csb;
   assign sclk_rise = ~d_sclk & s_sclk;
   assign sclk_fall = d_sclk & ~s_sclk;

   // Shifting by idx+1 yields 0 once idx+1 reaches NBITS, which is the required end-of-array DOUT.
   assign idx_inc = idx + 1'b1;
   assign rd_next = fuse >> idx_inc;

   assign fuse_data = fuse;
   assign unused_ok = ^{s_din, d_pgm, rd_next[NBITS-1:1]};

`ifdef EFUSE_LOCK_EN
   logic locked;
   assign burn_ok = ~locked;
`else
   assign burn_ok = 1'b1;
`endif

   // Session FSM: decodes program/read sessions, burns fuses and drives DOUT and status.
   always_ff @(posedge clk_1M) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         wcnt      <= '0;
         fuse      <= '0;
         DOUT      <= 1'b0;
         prog_done <= 1'b0;
         read_done <= 1'b0;
         err_short <= 1'b0;
         overrun   <= 1'b0;
`ifdef EFUSE_LOCK_EN
         locked    <= 1'b0;
`endif
      end else begin
         prog_done <= 1'b0;
         read_done <= 1'b0;
         case (state)
            IDLE: begin
               if (csb_fall) begin
                  idx <= '0;
                  if (s_pgm) begin
                     state <= PROG;
                     wcnt  <= '0;
`ifdef EFUSE_LOCK_EN
                     locked <= fuse[NBITS-1];
`endif
                  end else begin
                     state <= READ;
                     DOUT  <= fuse[0];
                  end
               end
            end
            PROG: begin
               if (csb_rise) begin
                  state     <= IDLE;
                  prog_done <= 1'b1;
                  DOUT      <= 1'b0;
               end else begin
                  // The rising-edge cycle itself is the first high cycle of the pulse.
                  if (sclk_rise) begin
                     wcnt <= s_pgm ? 8'd1 : 8'd0;
                  end else if (s_sclk && s_pgm && wcnt != 8'd255) begin
                     wcnt <= wcnt + 8'd1;
                  end
                  if (sclk_fall) begin
                     if (idx == IW'(NBITS)) begin
                        overrun <= 1'b1;
                     end else begin
                        if (wcnt >= 8'(PGM_MIN_WIDTH)) begin
                           if (burn_ok) fuse <= fuse | (NBITS'(1) << idx);
                        end else if (wcnt != 8'd0) begin
                           err_short <= 1'b1;
                        end
                        idx <= idx_inc;
                     end
                  end
               end
            end
            READ: begin
               if (csb_rise) begin
                  state     <= IDLE;
                  read_done <= 1'b1;
                  DOUT      <= 1'b0;
               end else if (sclk_rise) begin
                  if (idx == IW'(NBITS)) begin
                     overrun <= 1'b1;
                  end else begin
                     idx  <= idx_inc;
                     DOUT <= rd_next[0];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_efuse_macro_responder.sv
// tb/tb_efuse_macro_responder.sv - directed bench for efuse_macro_responder (honours EFUSE_LOCK_EN)
module tb_efuse_macro_responder;

   logic        clk_1M = 1'b0;
   logic        rst = 1'b1;
   logic        CSB = 1'b1;
   logic        PGM = 1'b0;
   logic        SCLK = 1'b0;
   logic        DIN = 1'b0;
   logic        DOUT;
   logic [31:0] fuse_data;
   logic        prog_done, read_done, err_short, overrun;

   int errors = 0;
   int checks = 0;
   int prog_cnt = 0;
   int read_cnt = 0;

   efuse_macro_responder #(.NBITS(32), .PGM_MIN_WIDTH(4)) dut (
      .clk_1M    (clk_1M),
      .rst       (rst),
      .CSB       (CSB),
      .PGM       (PGM),
      .SCLK      (SCLK),
      .DIN       (DIN),
      .DOUT      (DOUT),
      .fuse_data (fuse_data),
      .prog_done (prog_done),
      .read_done (read_done),
      .err_short (err_short),
      .overrun   (overrun)
   );

   always #5 clk_1M = ~clk_1M;

   always @(negedge clk_1M) begin
      if (prog_done) prog_cnt++;
      if (read_done) read_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_1M);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      CSB = 1'b1;
      PGM = 1'b0;
      SCLK = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(2);
   endtask

   // One program session: bit i of w on PGM, SCLK high for 'high' cycles per bit.
   task automatic prog_word(input logic [63:0] w, input int nbits, input int high);
      int p0;
      p0 = prog_cnt;
      PGM = 1'b1;
      tick(3);
      CSB = 1'b0;
      tick(4);
      for (int i = 0; i < nbits; i++) begin
         PGM = w[i];
         tick(1);
         SCLK = 1'b1;
         tick(high);
         SCLK = 1'b0;
         tick(3);
      end
      PGM = 1'b0;
      CSB = 1'b1;
      tick(5);
      chk("prog_done_pulse", 64'(prog_cnt - p0), 64'd1);
   endtask

   task automatic read_word(input logic [31:0] exp);
      int r0;
      r0 = read_cnt;
      SCLK = 1'b1;
      PGM = 1'b0;
      tick(3);
      CSB = 1'b0;
      tick(4);
      chk("dout_bit0", 64'(DOUT), 64'(exp[0]));
      for (int k = 1; k <= 32; k++) begin
         SCLK = 1'b0;
         tick(3);
         SCLK = 1'b1;
         tick(4);
         if (k < 32) chk($sformatf("dout_bit%0d", k), 64'(DOUT), 64'(exp[k]));
         else        chk("dout_after_last", 64'(DOUT), 64'd0);
      end
      SCLK = 1'b0;
      tick(3);
      CSB = 1'b1;
      tick(5);
      chk("read_done_pulse", 64'(read_cnt - r0), 64'd1);
      chk("dout_idle", 64'(DOUT), 64'd0);
      chk("read_no_overrun", 64'(overrun), 64'd0);
   endtask

   initial begin
      do_reset();
      chk("rst_dout", 64'(DOUT), 64'd0);
      chk("rst_fuse", 64'(fuse_data), 64'd0);
      chk("rst_prog_done", 64'(prog_done), 64'd0);
      chk("rst_read_done", 64'(read_done), 64'd0);
      chk("rst_err_short", 64'(err_short), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);

      prog_word(64'hA5A5_0001, 32, 5);
      chk("prog_a5a50001", 64'(fuse_data), 64'hA5A5_0001);
      chk("prog_no_err", 64'(err_short), 64'd0);
      read_word(32'hA5A5_0001);

      do_reset();
      chk("reset_clears_array", 64'(fuse_data), 64'd0);
      prog_word(64'h0000_FFFF, 32, 5);
      chk("or_low_half", 64'(fuse_data), 64'h0000_FFFF);
      prog_word(64'hFFFF_0000, 32, 5);
      chk("or_full", 64'(fuse_data), 64'hFFFF_FFFF);
      prog_word(64'h0, 32, 5);
      chk("or_zero_keeps", 64'(fuse_data), 64'hFFFF_FFFF);

      do_reset();
      prog_word(64'h1, 1, 2);
      chk("short_no_burn", 64'(fuse_data), 64'd0);
      chk("short_err", 64'(err_short), 64'd1);
      prog_word(64'h1, 1, 5);
      chk("short_then_burn", 64'(fuse_data), 64'd1);
      chk("short_err_sticky", 64'(err_short), 64'd1);
      do_reset();
      chk("short_err_cleared", 64'(err_short), 64'd0);

      prog_word(64'h3_0000_0000, 34, 5);
      chk("overrun_set", 64'(overrun), 64'd1);
      chk("overrun_no_wrap", 64'(fuse_data), 64'd0);
      chk("overrun_no_err", 64'(err_short), 64'd0);

      do_reset();
      prog_word(64'h7, 3, 5);
      chk("abort_bits", 64'(fuse_data), 64'h7);
      chk("abort_no_overrun", 64'(overrun), 64'd0);

      do_reset();
      prog_word(64'h8000_0000, 32, 5);
      prog_word(64'h0000_00FF, 32, 5);
`ifdef EFUSE_LOCK_EN
      chk("lock_blocks", 64'(fuse_data), 64'h8000_0000);
`else
      chk("no_lock", 64'(fuse_data), 64'h8000_00FF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
